md_seq: RTL and testbench

Multi-cycle multiply/divide unit with a start/busy handshake and the HI/LO registers it feeds. It sits in the EX stage beside the ALU. mult/multu/div/divu issue into it, it computes for a fixed latency, then commits to HI/LO. It also produces the stall request that holds any HI/LO-dependent instruction in decode until the result is committed.

---
 rtl/md_seq_if.sv | 24 ++
 rtl/md_seq.sv | 122 ++++++++++++
 tb/tb_md_seq.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/md_seq_if.sv
// Handshake and data bundle between the EX stage and the multiply/divide unit.
interface md_seq_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic        md_use;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, md_use,
    input  busy, stall, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, md_use,
    output busy, stall, hi, lo
  );
endinterface

// File: rtl/md_seq.sv
// Multi-cycle multiply/divide unit with its HI/LO registers.
// The result is computed at issue into holding registers. A down-counter then
// models the fixed latency, and the result commits to HI/LO when the counter
// expires. Divide by zero keeps the busy time but skips the commit.
module md_seq #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic     clk,
  input  logic     reset,
  md_seq_if.slave  bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic        issue, commit;
  logic [31:0] hold_hi, hold_lo;
  logic        hold_valid;
  logic [31:0] hi_q, lo_q;

  // Operand decode: op[1] selects divide, op[0] selects unsigned.
  logic        is_div, is_signed;
  logic        neg_a, neg_b, div_zero;
  logic [63:0] ext_a, ext_b, prod;
  logic [31:0] mag_a, mag_b, divisor, q_mag, r_mag, quo, rem;
  logic [31:0] res_hi, res_lo;

  assign is_div    = bus.op[1];
  assign is_signed = ~bus.op[0];

  // One 64x64 multiplier serves both signednesses. The low 64 bits of the
  // extended product are the exact 32x32 result.
  assign ext_a = {{32{is_signed & bus.a[31]}}, bus.a};
  assign ext_b = {{32{is_signed & bus.b[31]}}, bus.b};
  assign prod  = ext_a * ext_b;

  // The divider works on magnitudes and then fixes the signs. The quotient is
  // truncated toward zero and the remainder follows the dividend. The
  // 0x80000000 / -1 case falls out naturally as 0x80000000 rem 0.
  assign neg_a    = is_signed & bus.a[31];
  assign neg_b    = is_signed & bus.b[31];
  assign mag_a    = neg_a ? (32'd0 - bus.a) : bus.a;
  assign mag_b    = neg_b ? (32'd0 - bus.b) : bus.b;
  assign div_zero = (bus.b == 32'd0);
  assign divisor  = div_zero ? 32'd1 : mag_b;
  assign q_mag    = mag_a / divisor;
  assign r_mag    = mag_a % divisor;
  assign quo      = (neg_a ^ neg_b) ? (32'd0 - q_mag) : q_mag;
  assign rem      = neg_a ? (32'd0 - r_mag) : r_mag;

  assign res_hi = is_div ? rem : prod[63:32];
  assign res_lo = is_div ? quo : prod[31:0];

  // Next-state logic: issue in IDLE, count down in RUN, commit on count of 1.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_next = state;
    cnt_next   = cnt;
    issue      = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          issue      = 1'b1;
          state_next = RUN;
          cnt_next   = is_div ? 4'(DIV_CYCLES) : 4'(MUL_CYCLES);
        end
      end
      RUN: begin
        if (cnt == 4'd1) begin
          commit     = 1'b1;
          state_next = IDLE;
          cnt_next   = 4'd0;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, counter, holding registers and HI/LO.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      hold_hi    <= 32'd0;
      hold_lo    <= 32'd0;
      hold_valid <= 1'b0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (issue) begin
        hold_hi    <= res_hi;
        hold_lo    <= res_lo;
        hold_valid <= ~(is_div & div_zero);
      end
      if (commit) begin
        if (hold_valid) begin
          hi_q <= hold_hi;
          lo_q <= hold_lo;
        end
      end else if (state == IDLE) begin
        // mthi/mtlo land in IDLE only. With start in the same cycle, the
        // later commit overwrites them.
        if (bus.hi_we) hi_q <= bus.a;
        if (bus.lo_we) lo_q <= bus.a;
      end
    end
  end

  assign bus.busy  = (state == RUN);
  assign bus.stall = bus.md_use & (bus.start | bus.busy);
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

endmodule

// File: tb/tb_md_seq.sv
// Directed bench for md_seq: a vector table of operations plus hand-written
// sequences for the handshake, overlap and reset corner cases.
module tb_md_seq;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  md_seq_if bus();

  md_seq #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          cycles;
    logic        use_md;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load HI then LO through mthi/mtlo.
  task automatic preload(input logic [31:0] hv, input logic [31:0] lv);
    bus.a = hv; bus.hi_we = 1'b1;
    tick();
    bus.hi_we = 1'b0; bus.a = lv; bus.lo_we = 1'b1;
    tick();
    bus.lo_we = 1'b0;
    check("preload_hi", bus.hi, hv);
    check("preload_lo", bus.lo, lv);
  endtask

  // Issue one operation and follow it to commit.
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int cycles, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input logic use_md);
    logic [31:0] old_hi, old_lo;
    int n;
    old_hi = bus.hi;
    old_lo = bus.lo;
    bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1; bus.md_use = use_md;
    #1;
    check({name, "_stall_issue"}, 32'(bus.stall), 32'(use_md));
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a = ~a;           // operands must have been captured at issue
    bus.b = ~b;
    n = 0;
    while (bus.busy && n < 40) begin
      check({name, "_stall_busy"}, 32'(bus.stall), 32'(use_md));
      check({name, "_hi_hold"}, bus.hi, old_hi);
      check({name, "_lo_hold"}, bus.lo, old_lo);
      n++;
      tick();
    end
    check({name, "_busy_cycles"}, 32'(n), 32'(cycles));
    check({name, "_stall_after"}, 32'(bus.stall), 32'd0);
    check({name, "_hi"}, bus.hi, exp_hi);
    check({name, "_lo"}, bus.lo, exp_lo);
    bus.md_use = 1'b0;
  endtask

  initial begin
    int n;
    vecs[0]  = '{"mult_neg",   2'b00, 32'hFFFFFFFF, 32'h00000002, 32'hDEADBEEF, 32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFE, 5, 1'b1};
    vecs[1]  = '{"multu",      2'b01, 32'hFFFFFFFF, 32'h00000002, 32'hDEADBEEF, 32'h12345678, 32'h00000001, 32'hFFFFFFFE, 5, 1'b0};
    vecs[2]  = '{"div_neg",    2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hDEADBEEF, 32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, 1'b1};
    vecs[3]  = '{"divu",       2'b11, 32'h00000007, 32'h00000002, 32'hDEADBEEF, 32'h12345678, 32'h00000001, 32'h00000003, 10, 1'b1};
    vecs[4]  = '{"div_zero",   2'b10, 32'h00000005, 32'h00000000, 32'h00000011, 32'h00000022, 32'h00000011, 32'h00000022, 10, 1'b1};
    vecs[5]  = '{"div_ovf",    2'b10, 32'h80000000, 32'hFFFFFFFF, 32'hDEADBEEF, 32'h12345678, 32'h00000000, 32'h80000000, 10, 1'b0};
    vecs[6]  = '{"mult_min",   2'b00, 32'h80000000, 32'h80000000, 32'h0, 32'h0, 32'h40000000, 32'h00000000, 5, 1'b1};
    vecs[7]  = '{"multu_max",  2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'hFFFFFFFE, 32'h00000001, 5, 1'b1};
    vecs[8]  = '{"div_negdiv", 2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h0, 32'h0, 32'h00000001, 32'hFFFFFFFD, 10, 1'b1};
    vecs[9]  = '{"divu_big",   2'b11, 32'hFFFFFFFF, 32'h00000010, 32'h0, 32'h0, 32'h0000000F, 32'h0FFFFFFF, 10, 1'b0};
    vecs[10] = '{"divu_zero",  2'b11, 32'h00000005, 32'h00000000, 32'hAAAA5555, 32'h5555AAAA, 32'hAAAA5555, 32'h5555AAAA, 10, 1'b1};
    vecs[11] = '{"mult_mixed", 2'b00, 32'h00000003, 32'hFFFFFFFC, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFF4, 5, 1'b1};

    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.md_use = 1'b0;
    reset = 1'b1;
    tick(); tick();

    // Reset state and the combinational stall path.
    check("rst_hi", bus.hi, 32'd0);
    check("rst_lo", bus.lo, 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    bus.md_use = 1'b1; #1;
    check("rst_stall_nostart", 32'(bus.stall), 32'd0);
    bus.start = 1'b1; #1;
    check("rst_stall_start", 32'(bus.stall), 32'd1);
    bus.md_use = 1'b0; #1;
    check("rst_stall_nouse", 32'(bus.stall), 32'd0);
    bus.start = 1'b0;
    tick();
    check("rst_start_ignored", 32'(bus.busy), 32'd0);
    reset = 1'b0;
    tick();

    // Table-driven operations.
    for (int i = 0; i < 12; i++) begin
      preload(vecs[i].pre_hi, vecs[i].pre_lo);
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cycles,
             vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].use_md);
    end

    // Back-to-back: the second issue lands in the first idle cycle.
    preload(32'h0, 32'h0);
    run_op("b2b_first", 2'b11, 32'd7, 32'd2, 10, 32'd1, 32'd3, 1'b1);
    run_op("b2b_second", 2'b00, 32'd3, 32'hFFFFFFFC, 5, 32'hFFFFFFFF, 32'hFFFFFFF4, 1'b1);

    // A start plus mthi/mtlo mid-busy are ignored; busy is not extended.
    preload(32'h0, 32'h0);
    bus.op = 2'b00; bus.a = 32'hFFFFFFFF; bus.b = 32'd2; bus.start = 1'b1;
    tick();
    n = 0;
    while (bus.busy && n < 40) begin
      n++;
      if (n == 2) begin
        bus.start = 1'b1; bus.op = 2'b11; bus.a = 32'd9; bus.b = 32'd3;
        bus.hi_we = 1'b1; bus.lo_we = 1'b1;
      end else begin
        bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
      end
      check("ign_hi_hold", bus.hi, 32'd0);
      check("ign_lo_hold", bus.lo, 32'd0);
      tick();
    end
    bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    check("ign_busy_cycles", 32'(n), 32'd5);
    check("ign_hi", bus.hi, 32'hFFFFFFFF);
    check("ign_lo", bus.lo, 32'hFFFFFFFE);
    tick();
    check("ign_no_requeue", 32'(bus.busy), 32'd0);

    // mthi/mtlo in the issue cycle write at once, then the commit overwrites.
    bus.op = 2'b01; bus.a = 32'd3; bus.b = 32'd5;
    bus.start = 1'b1; bus.hi_we = 1'b1; bus.lo_we = 1'b1;
    tick();
    bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    check("same_cyc_hi_write", bus.hi, 32'd3);
    check("same_cyc_lo_write", bus.lo, 32'd3);
    n = 0;
    while (bus.busy && n < 40) begin
      n++;
      tick();
    end
    check("same_cyc_busy_cycles", 32'(n), 32'd5);
    check("same_cyc_hi", bus.hi, 32'd0);
    check("same_cyc_lo", bus.lo, 32'd15);

    // Reset in the third busy cycle of a divide aborts it with no commit.
    preload(32'h55, 32'h66);
    bus.op = 2'b11; bus.a = 32'd100; bus.b = 32'd7; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    check("mid_rst_busy_before", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_hi", bus.hi, 32'd0);
    check("mid_rst_lo", bus.lo, 32'd0);
    for (int i = 0; i < 12; i++) begin
      check("mid_rst_no_busy", 32'(bus.busy), 32'd0);
      tick();
    end
    check("mid_rst_hi_late", bus.hi, 32'd0);
    check("mid_rst_lo_late", bus.lo, 32'd0);

    // The unit is usable again after the abort.
    run_op("post_rst", 2'b11, 32'd100, 32'd7, 10, 32'd2, 32'd14, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
